// File: rtl/logic_sweep_ctrl_if.sv
// Stimulus/check bus between the sweep controller and the board/DUT side.
// master: the sweep controller. slave: the environment (button, DUT, reference, LEDs).
interface logic_sweep_ctrl_if #(
  parameter int unsigned N_IN = 2
);
  logic            start;
  logic            y_dut;
  logic            y_ref;
  logic [N_IN-1:0] a_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] first_fail_vec;
  logic            first_fail_valid;

  modport master (
    input  start, y_dut, y_ref,
    output a_out, busy, done, pass, err_cnt, first_fail_vec, first_fail_valid
  );

  modport slave (
    output start, y_dut, y_ref,
    input  a_out, busy, done, pass, err_cnt, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/logic_sweep_ctrl.sv
// Exhaustive sweep controller: drives every N_IN-bit vector onto a DUT, holds it
// SETTLE cycles, then compares y_dut against y_ref and accumulates the results.
// Optional macro SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module logic_sweep_ctrl #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 2
) (
  input logic                  clk,
  input logic                  rst,
  logic_sweep_ctrl_if.master   bus
);

  // SETTLE of 0 is treated as a single-cycle hold.
  localparam int unsigned SettleEff  = (SETTLE == 0) ? 1 : SETTLE;
  localparam logic [7:0]  SettleLast = 8'(SettleEff - 1);
  localparam logic [N_IN:0] ErrMax   = {1'b1, {N_IN{1'b0}}};

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [N_IN-1:0] a_out_q, a_out_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ffv_q, ffv_d;
  logic            ffvalid_q, ffvalid_d;

  logic            mismatch;
  logic            stop;

  assign mismatch = bus.y_dut ^ bus.y_ref;

  // a_out_q doubles as the vector counter; it is never stepped past all-ones.
  always_comb begin
`ifdef SWEEP_STOP_ON_FAIL_EN
    stop = (a_out_q == '1) || mismatch;
`else
    stop = (a_out_q == '1);
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_out_d   = a_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;

    unique case (state_q)
      StIdle, StDone: begin
        a_out_d = '0;
        busy_d  = 1'b0;
        if (bus.start) begin
          state_d   = StSettle;
          cnt_d     = '0;
          busy_d    = 1'b1;
          pass_d    = 1'b0;
          err_d     = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end

      StSettle: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == SettleLast) begin
          state_d = StSample;
        end
      end

      StSample: begin
        if (mismatch) begin
          if (err_q != ErrMax) begin
            err_d = err_q + 1'b1;
          end
          if (!ffvalid_q) begin
            ffv_d     = a_out_q;
            ffvalid_d = 1'b1;
          end
        end
        if (stop) begin
          // a_out keeps the last sampled vector through the DONE cycle.
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = StSettle;
          a_out_d = a_out_q + 1'b1;
          cnt_d   = '0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_out_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_out_q   <= a_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  assign bus.a_out            = a_out_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_cnt          = err_q;
  assign bus.first_fail_vec   = ffv_q;
  assign bus.first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Bench for logic_sweep_ctrl: De Morgan pair (~(a&b) vs ~a|~b) with a per-vector
// fault mask flipping y_dut. Expected sweep results come from a list-based model.
module tb_logic_sweep_ctrl;
  localparam int N = 2;
  localparam int S = 2;
  localparam int V = 1 << N;

  logic        clk;
  logic        rst;
  logic [15:0] fail_mask;
  int          total;
  int          bad;

  logic_sweep_ctrl_if #(.N_IN(N)) bus ();

  logic_sweep_ctrl #(.N_IN(N), .SETTLE(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.y_ref = ~bus.a_out[0] | ~bus.a_out[1];
  assign bus.y_dut = ~(bus.a_out[0] & bus.a_out[1]) ^ fail_mask[bus.a_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller has start=1 in cycle 0. Cycles below are counted from that start.
  task automatic run_sweep(input logic [15:0] mask, input int hold_end, input bit chain);
    int tested[$];
    int nf;
    int first;
    int d;
    int ea;
    nf    = 0;
    first = 0;
    tested.delete();
    for (int v = 0; v < V; v++) begin
      tested.push_back(v);
      if (mask[v]) begin
        if (nf == 0) first = v;
        nf++;
`ifdef SWEEP_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    d = 1 + tested.size() * (S + 1);
    fail_mask = mask;
    step();
    for (int k = 1; k <= d; k++) begin
      ea = (k < d) ? tested[(k - 1) / (S + 1)] : tested[tested.size() - 1];
      chk("a_out", 32'(bus.a_out), ea);
      chk("busy", 32'(bus.busy), (k < d) ? 1 : 0);
      chk("done", 32'(bus.done), (k == d) ? 1 : 0);
      if (k == 1) begin
        chk("err_clr", 32'(bus.err_cnt), 0);
        chk("ffvalid_clr", 32'(bus.first_fail_valid), 0);
        chk("pass_clr", 32'(bus.pass), 0);
      end
      if (k == d) begin
        chk("err_cnt", 32'(bus.err_cnt), nf);
        chk("ffvalid", 32'(bus.first_fail_valid), (nf > 0) ? 1 : 0);
        chk("ffvec", 32'(bus.first_fail_vec), first);
        chk("pass", 32'(bus.pass), (nf == 0) ? 1 : 0);
        if (chain) begin
          bus.start = 1'b1;
        end else begin
          bus.start = 1'b0;
          step();
          chk("post_done", 32'(bus.done), 0);
          chk("post_busy", 32'(bus.busy), 0);
          chk("post_a_out", 32'(bus.a_out), 0);
          chk("pass_held", 32'(bus.pass), (nf == 0) ? 1 : 0);
          chk("err_held", 32'(bus.err_cnt), nf);
        end
      end else begin
        bus.start = (k < hold_end);
        step();
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    fail_mask = '0;
    step();
    step();
    chk("rst_a_out", 32'(bus.a_out), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_pass", 32'(bus.pass), 0);
    chk("rst_err", 32'(bus.err_cnt), 0);
    chk("rst_ffvec", 32'(bus.first_fail_vec), 0);
    chk("rst_ffvalid", 32'(bus.first_fail_valid), 0);
    rst = 1'b0;
    step();

    // Clean sweep, single fault, all faults, fault at 01.
    bus.start = 1'b1; run_sweep(16'h0000, 0, 1'b0);
    bus.start = 1'b1; run_sweep(16'h0004, 0, 1'b0);
    bus.start = 1'b1; run_sweep(16'h000f, 0, 1'b0);
    bus.start = 1'b1; run_sweep(16'h0002, 0, 1'b0);

    // start held high through the sweep must not restart it.
    bus.start = 1'b1; run_sweep(16'h0008, 12, 1'b0);

    // Restart in the DONE cycle after a failing sweep; second sweep is clean.
    bus.start = 1'b1; run_sweep(16'h0005, 0, 1'b1);
    run_sweep(16'h0000, 0, 1'b0);

    // Random fault patterns.
    for (int i = 0; i < 8; i++) begin
      bus.start = 1'b1;
      run_sweep(16'($urandom_range(0, 15)), 0, 1'b0);
    end

    // Reset mid-sweep (cycle 6): sweep abandoned, no done pulse.
    fail_mask = 16'h0001;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k < 6; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_a_out", 32'(bus.a_out), 0);
    chk("mid_rst_err", 32'(bus.err_cnt), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    for (int k = 0; k < 15; k++) begin
      step();
      chk("no_done_after_rst", 32'(bus.done), 0);
    end

    // Recovery sweep after the reset.
    bus.start = 1'b1; run_sweep(16'h0006, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
